mul_seq_ctl: RTL and testbench
==============================

// Module: mul_seq_ctl
// PURPOSE
//  Multi-cycle sequencer for the MIPS-lite multiply unit. Runs MULTU and MADDU as an
//  iterative shift-add over WIDTH cycles and owns the architectural HI/LO registers.
//  Raises a pipeline stall while a multiply is in flight and an MFHI/MFLO or a new
//  multiply arrives. Sits in EX beside the ALU; driven by ALU-control decode (ALUOp/Funct, sel2).
// PARAMETERS
//  WIDTH   32   operand width; HI/LO each WIDTH bits, product 2*WIDTH bits
//  CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        decoded MULTU/MADDU in EX this cycle (ALU op 3'b101)
//  op_maddu   in   1        1 = MADDU (accumulate into HI:LO), 0 = MULTU (from sel2)
//  op_a       in   WIDTH    rs operand, unsigned
//  op_b       in   WIDTH    rt operand, unsigned
//  rd_req     in   1        MFHI/MFLO in EX this cycle (sel3 = 2'b00/2'b01)
//  busy       out  1        multiply in flight (state != IDLE)
//  stall      out  1        freeze IF/ID/EX; hold start/rd_req/operands stable
//  done       out  1        one-cycle pulse on the cycle HI/LO take the new value
//  hi         out  WIDTH    HI register
//  lo         out  WIDTH    LO register
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cnt=0, P=0, hi=0, lo=0, busy=0, done=0, stall=0.
//  Datapath: P is a 2*WIDTH+1 bit reg {carry, upper[WIDTH], lower[WIDTH]}; M = multiplicand reg.
//  States:
//   IDLE : start=1 -> latch M=op_a, P={1'b0,0,op_b}, mode=op_maddu, cnt=0 -> RUN.
//          start=0 -> stay. rd_req in IDLE never stalls.
//   RUN  : per cycle: if P[0], upper = upper + M (carry into P[2W]); then P >>= 1 (logical).
//          cnt++. When cnt==WIDTH-1 on this edge: mode=0 -> COMMIT, mode=1 -> ACC.
//   ACC  : (MADDU only) sum = {hi,lo} + P[2W-1:0], mod 2**(2*WIDTH), carry-out dropped -> COMMIT.
//   COMMIT: {hi,lo} <= product (MULTU) or sum (MADDU); done=1 this cycle; -> IDLE.
//  Latency from start edge: MULTU done at edge WIDTH+1 (33); MADDU at WIDTH+2 (34).
//  HI/LO update only in COMMIT (atomic 64-bit write); never partially visible.
//  stall = busy & (start | rd_req). The start that launched the op is consumed in IDLE,
//   so it does not stall itself; EX advances and the next instruction is evaluated.
//  start while busy: ignored (no relatch), stall held; re-accepted at IDLE after COMMIT.
//  rd_req while busy: stall until the cycle after COMMIT; hi/lo then hold new value.
//  start & rd_req together in IDLE: start accepted, read returns pre-multiply hi/lo (program order).
//  done and start in same cycle: start not accepted (state=COMMIT), stall=1; accepted next cycle.
//  Operand zero: still runs full WIDTH iterations (no early-out); result 0.
//  rst_n low mid-operation: abort immediately, all state/outputs to reset values; HI/LO = 0.
//  op_maddu/op_a/op_b ignored except on accepting edge.
// STRUCTURE
//  Shared package/include (mips_defs.vh): F_MULTU=6'd25, F_MADDU=6'd1, ALU_MUL=3'b101,
//   state encodings S_IDLE/S_RUN/S_ACC/S_COMMIT (2-bit).
//  One sub-module natural: mul_shift_add_dp (M, P, adder, shifter); mul_seq_ctl keeps FSM,
//   counter, HI/LO regs, stall logic.
// TESTING
//  1. multu a=32'hFFFFFFFF b=32'hFFFFFFFF -> done at edge 33, hi=32'hFFFFFFFE lo=32'h00000001.
//  2. hi:lo=0:5, maddu a=3 b=4 -> done at edge 34, hi=0 lo=17; then maddu a=b=32'h80000000
//     -> hi=32'h40000000 lo=17.
//  3. multu 7*6, rd_req=1 from edge 2 -> stall=1 edges 2..33, lo=42 visible, stall=0 at edge 34.
//  4. multu started, second start at edge 5 -> stall=1, no relatch; second op begins edge 34.
//  5. multu started, rst_n=0 at edge 10 -> busy=0, hi=lo=0 immediately; no done pulse.
//  6. multu a=0 b=32'h12345678 -> done at edge 33, hi=lo=0; rd_req in IDLE -> stall=0.

Source files
------------

// File: rtl/mul_seq_ctl_pkg.sv
// Shared definitions for the EX-stage multiply sequencer.
//   F_MULTU / F_MADDU : funct codes decoded upstream into start/op_maddu
//   ALU_MUL           : ALU op that selects the multiply unit
//   state_t           : sequencer state encoding (2 bits)
`timescale 1ns/1ps
package mul_seq_ctl_pkg;

    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MADDU = 6'd1;
    localparam logic [2:0] ALU_MUL = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_ACC    = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/mul_seq_ctl_dp.sv
// Shift-add datapath for the multiply sequencer.
// Holds the multiplicand M and the 2*WIDTH+1 bit partial-product register
// P = {carry, upper, lower}. One iteration per 'step'.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture M = op_a, P = {0, 0, op_b}
//   step       : one shift-add iteration
//   op_a, op_b : operands (only sampled on load)
//   prod       : P[2*WIDTH-1:0], the full product after WIDTH steps
`timescale 1ns/1ps
module mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] prod
);

    logic [WIDTH-1:0]   m_reg;
    logic [2*WIDTH:0]   p_reg;
    logic [2*WIDTH:0]   p_next;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   pre_shift;

    // Multiplicand is added only when the current low bit of P is set.
    // P[2W] is always zero between iterations (it was shifted out), so
    // folding it into the add is harmless and keeps every bit of P live.
    assign addend    = m_reg & {WIDTH{p_reg[0]}};
    assign upper_sum = {p_reg[2*WIDTH], p_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign pre_shift = {upper_sum, p_reg[WIDTH-1:0]};

    // Logical shift right by one: bit gi takes bit gi+1, MSB fills with 0.
    genvar gi;
    generate
        for (gi = 0; gi < 2*WIDTH; gi++) begin : g_shift
            assign p_next[gi] = pre_shift[gi+1];
        end
    endgenerate
    assign p_next[2*WIDTH] = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg <= '0;
            p_reg <= '0;
        end else if (load) begin
            m_reg <= op_a;
            p_reg <= {1'b0, {WIDTH{1'b0}}, op_b};
        end else if (step) begin
            p_reg <= p_next;
        end
    end

    assign prod = p_reg[2*WIDTH-1:0];

endmodule

// File: rtl/mul_seq_ctl.sv
// Multi-cycle MULTU/MADDU sequencer with architectural HI/LO registers.
// Accepts an op in IDLE, runs WIDTH shift-add iterations, optionally
// accumulates into HI:LO, then commits HI:LO atomically.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : MULTU/MADDU in EX this cycle
//   op_maddu   : 1 = accumulate into HI:LO, 0 = plain multiply
//   op_a, op_b : unsigned operands, sampled only on the accepting edge
//   rd_req     : MFHI/MFLO in EX this cycle
//   busy       : op in flight (state not IDLE)
//   stall      : freeze front end while busy and a start/read is waiting
//   done       : high for the COMMIT cycle; HI/LO change at its closing edge
//   hi, lo     : architectural HI/LO
`timescale 1ns/1ps
module mul_seq_ctl
    import mul_seq_ctl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_maddu,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               mode_reg, mode_next;
    logic [2*WIDTH-1:0] hilo_reg;
    logic [2*WIDTH-1:0] res_reg;
    logic [2*WIDTH-1:0] prod;
    logic               dp_load;
    logic               dp_step;

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dp_load),
        .step  (dp_step),
        .op_a  (op_a),
        .op_b  (op_b),
        .prod  (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    dp_load    = 1'b1;
                    cnt_next   = '0;
                    mode_next  = op_maddu;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                dp_step  = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = mode_reg ? S_ACC : S_COMMIT;
                end
            end
            S_ACC: begin
                state_next = S_COMMIT;
            end
            S_COMMIT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The accumulate sum is registered in ACC so the wide add does not sit
    // in series with the HI/LO write; carry out of bit 2W-1 is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_reg <= '0;
        end else if (state_reg == S_ACC) begin
            res_reg <= hilo_reg + prod;
        end
    end

    // HI/LO change only here, as a single 2W-bit write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hilo_reg <= '0;
        end else if (state_reg == S_COMMIT) begin
            hilo_reg <= mode_reg ? res_reg : prod;
        end
    end

    assign busy  = (state_reg != S_IDLE);
    assign done  = (state_reg == S_COMMIT);
    // The launching start is consumed in IDLE (busy still 0), so it never
    // stalls itself; only a following start or read stalls.
    assign stall = busy & (start | rd_req);
    assign hi    = hilo_reg[2*WIDTH-1:WIDTH];
    assign lo    = hilo_reg[WIDTH-1:0];

endmodule

// File: tb/tb_mul_seq_ctl.sv
`timescale 1ns/1ps
module tb_mul_seq_ctl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op_maddu;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        rd_req;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mul_seq_ctl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_maddu (op_maddu),
        .op_a     (op_a),
        .op_b     (op_b),
        .rd_req   (rd_req),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Scoreboard: expected architectural HI:LO after each op and the cycle
    // on which done must be observed.
    typedef struct {
        logic [63:0] res;
        int          done_cyc;
        int          id;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] model_hilo = '0;
    int          n_issued = 0;

    // Monitor: done is seen during the COMMIT cycle; HI/LO are compared on
    // the following sample, after the committing edge.
    exp_t cur;
    bit   pend = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) begin
                chk("result_hi", {32'd0, hi}, {32'd0, cur.res[63:32]});
                chk("result_lo", {32'd0, lo}, {32'd0, cur.res[31:0]});
                $display("txn %0d: hi=%h lo=%h expected %h", cur.id, hi, lo, cur.res);
                pend = 0;
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    cur = sbq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(cur.done_cyc));
                    pend = 1;
                end
            end
        end
    end

    // Call shortly after a rising edge. Holds start until the sequencer is
    // free, then records the expected result from plain arithmetic.
    task automatic issue(input bit md, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [63:0] p;
        n        = 0;
        start    = 1'b1;
        op_maddu = md;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
        while (stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", 64'd1, 64'd0);
            start = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        p = 64'(a) * 64'(b);
        model_hilo = md ? (model_hilo + p) : p;
        sbq.push_back('{res: model_hilo, done_cyc: cyc + (md ? WIDTH + 1 : WIDTH), id: n_issued});
        n_issued++;
        start    = 1'b0;
        op_maddu = 1'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || pend) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1;
        int c0;
        rst_n    = 1'b0;
        start    = 1'b1;
        op_maddu = 1'b0;
        op_a     = 32'h1;
        op_b     = 32'h1;
        rd_req   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",  {63'd0, busy},  64'd0);
        chk("reset_done",  {63'd0, done},  64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        chk("reset_hi",    {32'd0, hi},    64'd0);
        chk("reset_lo",    {32'd0, lo},    64'd0);
        start  = 1'b0;
        rd_req = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;

        // Largest operands.
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drain();
        chk("t1_hi", {32'd0, hi}, {32'd0, 32'hFFFFFFFE});
        chk("t1_lo", {32'd0, lo}, {32'd0, 32'h00000001});

        // Accumulate, including back-to-back issue and a carry into HI.
        issue(1'b0, 32'd1, 32'd5);
        issue(1'b1, 32'd3, 32'd4);
        drain();
        chk("t2_hi", {32'd0, hi}, 64'd0);
        chk("t2_lo", {32'd0, lo}, 64'd17);
        issue(1'b1, 32'h80000000, 32'h80000000);
        drain();
        chk("t2b_hi", {32'd0, hi}, {32'd0, 32'h40000000});
        chk("t2b_lo", {32'd0, lo}, 64'd17);

        // Read request while busy stalls through COMMIT.
        issue(1'b0, 32'd7, 32'd6);
        @(negedge clk);
        chk("t3_no_self_stall", {63'd0, stall}, 64'd0);
        chk("t3_busy",          {63'd0, busy},  64'd1);
        @(posedge clk);
        #1;
        rd_req = 1'b1;
        for (int i = 2; i <= 34; i++) begin
            @(negedge clk);
            chk($sformatf("t3_stall_e%0d", i), {63'd0, stall}, (i <= 33) ? 64'd1 : 64'd0);
        end
        chk("t3_lo", {32'd0, lo}, 64'd42);
        rd_req = 1'b0;
        drain();

        // Second start while busy: ignored until IDLE, then accepted.
        issue(1'b0, 32'h0001_0003, 32'h0002_0005);
        e1 = cyc;
        repeat (4) @(posedge clk);
        #1;
        issue(1'b0, 32'h0000_0011, 32'h0000_0013);
        chk("t4_second_accept_edge", 64'(cyc), 64'(e1 + 34));
        drain();

        // Reset in mid-flight aborts everything.
        issue(1'b0, 32'hDEAD_BEEF, 32'h1234_5679);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_done", {63'd0, done}, 64'd0);
        chk("t5_hi",   {32'd0, hi},   64'd0);
        chk("t5_lo",   {32'd0, lo},   64'd0);
        sbq.delete();
        model_hilo = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        // Zero operand still takes the full latency; reads in IDLE never stall.
        issue(1'b0, 32'd3, 32'd3);
        drain();
        issue(1'b0, 32'd0, 32'h12345678);
        drain();
        chk("t6_hi", {32'd0, hi}, 64'd0);
        chk("t6_lo", {32'd0, lo}, 64'd0);
        rd_req = 1'b1;
        @(negedge clk);
        chk("t6_idle_read_stall", {63'd0, stall}, 64'd0);
        @(posedge clk);
        #1;
        c0 = cyc;
        issue(1'b1, 32'd2, 32'd2);
        chk("t6_start_read_accept", 64'(cyc), 64'(c0 + 1));
        chk("t6_read_old_lo", {32'd0, lo}, 64'd0);
        rd_req = 1'b0;
        drain();

        // Randomised sequence with random gaps (gap 0 exercises start-while-busy).
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'd0;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            issue(1'($urandom), a, b);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
